// File: rtl/twiddle_issue.sv
// Twiddle issue unit: pairs 64 streamed samples with W64 twiddles, drives an external
// complex multiplier and rounds/saturates its Q2.30 products back to Q1.15.
module twiddle_issue #(
  parameter int MULT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  stage,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [4:0]  tw_addr,
  input  logic [31:0] tw_data,
  output logic [31:0] mult_multiplier,
  output logic [15:0] mult_multiplicand1,
  output logic [15:0] mult_multiplicand2,
  input  logic [63:0] mult_results,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fsm_state
);

  // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on state, never on s_valid. m_valid has no ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      k_q;
  logic [5:0]      out_cnt_q;
  logic [2:0]      stage_q;
  logic [MULT_LAT:0] vld_q;
  logic [31:0]     sample_q;
  logic [31:0]     tw_hold_q;
  logic            accept;
  logic            start_ok;
  logic            last_in;
  logic            last_out;
  logic [5:0]      mask_w;
  logic [4:0]      low_k;
  logic [4:0]      addr_w;

  function automatic logic [15:0] scale(input logic [31:0] x);
    logic signed [32:0] sum;
    logic signed [17:0] sh;
    sum = $signed({x[31], x}) + 33'sd16384;
    sh  = 18'(sum >>> 15);
    if (sh > 18'sd32767)
      scale = 16'h7fff;
    else if (sh < -18'sd32768)
      scale = 16'h8000;
    else
      scale = sh[15:0];
  endfunction

  assign accept   = (state_q == RUN) && s_valid;
  assign start_ok = start && (state_q == IDLE);
  assign last_in  = accept && (k_q == 6'd63);
  assign last_out = vld_q[MULT_LAT] && (out_cnt_q == 6'd63);

  assign s_ready   = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

  // Exponent for k within a group of 2^stage butterflies, scaled to the 64-point ROM.
  assign mask_w  = (6'd1 << stage_q) - 6'd1;
  assign low_k   = k_q[4:0] & mask_w[4:0];
  assign addr_w  = low_k << (3'd5 - stage_q);
  assign tw_addr = (state_q == RUN) ? addr_w : 5'd0;

  // The ROM answers one cycle after the address, so the twiddle is forwarded in that
  // cycle alongside the registered sample, and held afterwards.
  assign mult_multiplier    = vld_q[0] ? tw_data : tw_hold_q;
  assign mult_multiplicand1 = sample_q[31:16];
  assign mult_multiplicand2 = sample_q[15:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_in) state_d = DRAIN;
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= 6'd0;
      out_cnt_q <= 6'd0;
      stage_q   <= 3'd0;
      vld_q     <= '0;
      sample_q  <= 32'd0;
      tw_hold_q <= 32'd0;
      m_valid   <= 1'b0;
      m_data    <= 32'd0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        k_q     <= 6'd0;
        stage_q <= (stage > 3'd5) ? 3'd5 : stage;
      end else if (accept) begin
        k_q <= k_q + 6'd1;
      end
      vld_q <= {vld_q[MULT_LAT-1:0], accept};
      if (accept)
        sample_q <= s_data;
      if (vld_q[0])
        tw_hold_q <= tw_data;
      m_valid <= vld_q[MULT_LAT];
      done    <= last_out;
      if (start_ok)
        out_cnt_q <= 6'd0;
      else if (vld_q[MULT_LAT])
        out_cnt_q <= out_cnt_q + 6'd1;
      if (vld_q[MULT_LAT])
        m_data <= {scale(mult_results[63:32]), scale(mult_results[31:0])};
    end
  end

endmodule

// File: doc/twiddle_issue.md
TWIDDLE_ISSUE -- requirements
Module: twiddle_issue

Interface
REQ-001 Parameter MULT_LAT, default 1, clock cycles from the multiplier operand ports to the mult_results port (range 1-4).
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a 64-sample pass; ignored unless the FSM is in IDLE.
REQ-005 stage  input  3  FFT stage 0..5, latched on an accepted start; values 6-7 are treated as 5.
REQ-006 s_valid / s_ready  input / output  1 / 1  sample handshake; a transfer occurs when both are high.
REQ-007 s_data  input  32  sample {re[31:16], im[15:0]}, signed Q1.15.
REQ-008 tw_addr  output  5  twiddle ROM address (exponent e of W64^e).
REQ-009 tw_data  input  32  twiddle {re,im} Q1.15, valid one cycle after tw_addr.
REQ-010 mult_multiplier  output  32  registered twiddle {re,im} to the complex multiplier.
REQ-011 mult_multiplicand1 / mult_multiplicand2  output  16 / 16  registered sample re / im.
REQ-012 mult_results  input  64  product {re[63:32], im[31:0]}: re = tw_re*s_re - tw_im*s_im; im = tw_re*s_im + tw_im*s_re; both Q2.30.
REQ-013 m_valid / m_data  output  1 / 32  result strobe and result {re,im} Q1.15; no backpressure.
REQ-014 busy / done  output  1 / 1  pass in progress / one-cycle pulse at pass end.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN after the 64th accepted sample; DRAIN->IDLE when the 64th m_valid is emitted.
REQ-016 s_ready is high only in RUN; it is low in IDLE and DRAIN and in the cycle after the 64th accept.
REQ-017 Sample counter k (6 bits) is cleared on start and increments on each accepted sample.
REQ-018 tw_addr = (k mod 2^stage) << (5 - stage), driven combinationally in the accept cycle; stage 0 therefore always gives address 0.
REQ-019 Accept cycle t: the sample is registered. At t+1, mult_multiplier <= tw_data and the multiplicand ports <= the registered sample; these ports hold their last values when no new sample is issued.
REQ-020 A 1+MULT_LAT valid shift pipeline tracks issued operands; mult_results is sampled at t+1+MULT_LAT.
REQ-021 m_valid is high at t+2+MULT_LAT; total accept-to-output latency is MULT_LAT+2 cycles. Bubbles are preserved and results stay in order.
REQ-022 Scaling per component: y = (x + 2^14) >>> 15, arithmetic shift, then saturate to [-32768, 32767].
REQ-023 m_data is held while m_valid is low.
REQ-024 done pulses in the same cycle as the 64th m_valid, and busy falls in the next cycle.
REQ-025 busy is high in RUN and DRAIN.
REQ-026 start during RUN or DRAIN is ignored, and a stage change mid-pass has no effect.
REQ-027 s_valid during IDLE or DRAIN is not accepted.
REQ-028 A start in the same cycle as done (DRAIN->IDLE) is ignored; a new pass needs a start in IDLE.

Reset
REQ-029 While reset is high: FSM=IDLE, k=0, stage register=0, all valid pipeline bits cleared, s_ready=0, m_valid=0, done=0, busy=0, m_data=0, tw_addr=0, and mult_multiplier and both multiplicands=0.
REQ-030 Reset mid-pass discards all in-flight results; no m_valid or done is produced for them afterwards.
REQ-031 Reset has priority over start in the same cycle.

Verification
REQ-032 MULT_LAT=1, stage=0, tw ROM[0]={0x7FFF,0x0000}, one sample {0x4000,0x2000} -> m_data={0x4000,0x2000}, 3 cycles after accept.
REQ-033 Saturation: twiddle {0x8000,0x0000} with sample {0x8000,0x0000} -> m_data={0x7FFF,0x0000}.
REQ-034 stage=3, 64 back-to-back samples -> tw_addr sequence 0,4,8,...,28 repeated 8 times.
REQ-035 Full pass with s_valid toggled randomly -> exactly 64 m_valid, in order, each matching a reference model.
REQ-036 done pulse coincides with the 64th m_valid, and s_ready=0 after the 64th accept.
REQ-037 Reset asserted after 10 accepts -> no further m_valid, FSM in IDLE; a fresh start runs a correct full pass.
